// File: rtl/fifo_reader_if.sv
// Registered VALID/READY output stream of the FIFO read controller.
// The master drives data and VALID; the slave returns READY.
interface fifo_reader_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] dataOut;
    logic             VALID;
    logic             READY;

    modport master (
        output dataOut,
        output VALID,
        input  READY
    );

    modport slave (
        input  dataOut,
        input  VALID,
        output READY
    );
endinterface

// File: rtl/fifo_reader.sv
// Read-side controller for fifo_n: issues reads, absorbs the one-cycle read latency in a
// 2-entry skid buffer, and presents words on a registered VALID/READY stream with a delivered-word count.
module fifo_reader #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             EN,
    input  logic             EMPTY,
    input  logic [WIDTH-1:0] fifoData,
    output logic             RD,
    output logic [CNT_W-1:0] COUNT,
    fifo_reader_if.master    strm
);

    logic [1:0]       occ;
    logic             pend;
    logic [WIDTH-1:0] second_word;
    logic             pop;
    logic [2:0]       fill;
    logic [1:0]       slot;

    assign pop  = strm.VALID & strm.READY;
    // Occupancy after this edge; a read is only issued if its word will still fit.
    assign fill = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
    assign slot = occ - {1'b0, pop};
    assign RD   = Rst & EN & ~EMPTY & (fill < 3'd2);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            occ          <= 2'd0;
            pend         <= 1'b0;
            second_word  <= '0;
            strm.dataOut <= '0;
            strm.VALID   <= 1'b0;
            COUNT        <= '0;
        end else begin
            if (pop && occ == 2'd2) begin
                strm.dataOut <= second_word;
            end
            // The arriving word lands in the first free slot after the head has shifted.
            if (pend) begin
                if (slot == 2'd0) begin
                    strm.dataOut <= fifoData;
                end else begin
                    second_word <= fifoData;
                end
            end
            occ        <= fill[1:0];
            pend       <= RD;
            strm.VALID <= (fill != 3'd0);
            COUNT      <= COUNT + CNT_W'(pop);
        end
    end

    a_no_overflow : assert property (@(posedge Clk) disable iff (!Rst) fill <= 3'd2);

endmodule

// File: tb/tb_fifo_reader.sv
// Randomized/directed bench for fifo_reader with a behavioural fifo_n model and an
// in-order scoreboard of delivered words.
module tb_fifo_reader;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    logic             Clk = 1'b0;
    logic             Rst;
    logic             EN;
    logic             EMPTY;
    logic             RD;
    logic [WIDTH-1:0] fifoData;
    logic [CNT_W-1:0] COUNT;

    fifo_reader_if #(.WIDTH(WIDTH)) strm_if ();

    fifo_reader #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .EN      (EN),
        .EMPTY   (EMPTY),
        .fifoData(fifoData),
        .RD      (RD),
        .COUNT   (COUNT),
        .strm    (strm_if)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // fifo_n model: words pushed by the stimulus, read data appears the cycle after RD.
    logic [WIDTH-1:0] mem [0:1023];
    int   pushed = 0;
    int   popped = 0;
    logic rd_when_empty = 1'b0;

    assign EMPTY = (pushed == popped);

    always @(posedge Clk) begin
        if (RD && EMPTY) rd_when_empty <= 1'b1;
        if (RD && !EMPTY) begin
            fifoData <= mem[popped];
            popped   <= popped + 1;
        end else begin
            fifoData <= $urandom;
        end
    end

    logic [WIDTH-1:0] got_q [$];
    bit               tr_rd [$];
    bit               tr_valid [$];
    logic [WIDTH-1:0] tr_data [$];
    int               rd_cnt;
    int               stab_err;
    logic             prev_hold;
    logic [WIDTH-1:0] prev_data;

    task automatic push_word(input logic [WIDTH-1:0] w);
        mem[pushed] = w;
        pushed++;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe the settled pre-edge values of one cycle, then advance past the next edge.
    task automatic apply_cycle();
        #2;
        if (Rst) begin
            if (prev_hold && (strm_if.VALID !== 1'b1 || strm_if.dataOut !== prev_data)) stab_err++;
            if (RD === 1'b1) rd_cnt++;
            if (strm_if.VALID === 1'b1 && strm_if.READY === 1'b1) got_q.push_back(strm_if.dataOut);
            prev_hold = (strm_if.VALID === 1'b1) && (strm_if.READY === 1'b0);
            prev_data = strm_if.dataOut;
        end else begin
            prev_hold = 1'b0;
        end
        tr_rd.push_back(RD === 1'b1);
        tr_valid.push_back(strm_if.VALID === 1'b1);
        tr_data.push_back(strm_if.dataOut);
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_traces();
        tr_rd.delete();
        tr_valid.delete();
        tr_data.delete();
        rd_cnt = 0;
    endtask

    task automatic run_until(input string tag, input int target, input int budget);
        int n = 0;
        while (got_q.size() < target && n < budget) begin
            apply_cycle();
            n++;
        end
        check_output({tag, "_timeout"}, 64'(got_q.size() >= target), 64'd1);
    endtask

    task automatic check_seq(input string tag, input int start, input int n, input logic [WIDTH-1:0] first);
        int errs = 0;
        for (int i = 0; i < n; i++) begin
            if (start + i >= got_q.size() || got_q[start + i] !== first + WIDTH'(i)) errs++;
        end
        check_output(tag, 64'(errs), 64'd0);
    endtask

    initial begin
        logic [8:0] rd_mask;
        logic [8:0] v_mask;
        int         errs;

        Rst = 1'b0;
        EN = 1'b1;
        strm_if.READY = 1'b0;
        rd_cnt = 0;
        stab_err = 0;
        prev_hold = 1'b0;
        prev_data = '0;

        // Reset held for two edges with data available.
        for (int i = 1; i <= 5; i++) push_word(WIDTH'(i));
        apply_cycle();
        apply_cycle();
        check_output("reset_rd", 64'(RD), 64'd0);
        check_output("reset_valid", 64'(strm_if.VALID), 64'd0);
        check_output("reset_data", 64'(strm_if.dataOut), 64'd0);
        check_output("reset_count", 64'(COUNT), 64'd0);

        // Streaming drain of 1..5.
        Rst = 1'b1;
        strm_if.READY = 1'b1;
        clear_traces();
        repeat (9) apply_cycle();
        errs = 0;
        for (int i = 0; i < 9; i++) begin
            rd_mask[i] = tr_rd[i];
            v_mask[i]  = tr_valid[i];
        end
        for (int i = 2; i <= 6; i++) if (tr_data[i] !== WIDTH'(i - 1)) errs++;
        check_output("drain_rd_pattern", 64'(rd_mask), 64'(9'b000011111));
        check_output("drain_valid_pattern", 64'(v_mask), 64'(9'b001111100));
        check_output("drain_data", 64'(errs), 64'd0);
        check_output("drain_count", 64'(COUNT), 64'd5);
        check_output("drain_got", 64'(got_q.size()), 64'd5);
        check_output("drain_rd_empty", 64'(rd_when_empty), 64'd0);

        // Backpressure: only two reads while stalled, head held.
        strm_if.READY = 1'b0;
        clear_traces();
        for (int i = 1; i <= 5; i++) push_word(WIDTH'(i));
        repeat (6) apply_cycle();
        errs = 0;
        for (int i = 2; i <= 5; i++) if (tr_data[i] !== WIDTH'(1)) errs++;
        check_output("bp_reads", 64'(rd_cnt), 64'd2);
        check_output("bp_valid", 64'(strm_if.VALID), 64'd1);
        check_output("bp_data", 64'(strm_if.dataOut), 64'd1);
        check_output("bp_stable", 64'(errs), 64'd0);
        strm_if.READY = 1'b1;
        run_until("bp", 10, 30);
        repeat (3) apply_cycle();
        check_seq("bp_order", 5, 5, WIDTH'(1));
        check_output("bp_no_dup", 64'(got_q.size()), 64'd10);
        check_output("bp_count", 64'(COUNT), 64'd10);

        // Random READY over words 0..99, counter restarted by reset.
        strm_if.READY = 1'b0;
        Rst = 1'b0;
        apply_cycle();
        apply_cycle();
        Rst = 1'b1;
        got_q.delete();
        stab_err = 0;
        for (int i = 0; i < 100; i++) push_word(WIDTH'(i));
        for (int n = 0; n < 3000 && got_q.size() < 100; n++) begin
            strm_if.READY = 1'($urandom_range(0, 1));
            apply_cycle();
        end
        check_output("rand_timeout", 64'(got_q.size() >= 100), 64'd1);
        check_seq("rand_order", 0, 100, WIDTH'(0));
        check_output("rand_count", 64'(COUNT), 64'd100);
        check_output("rand_stable", 64'(stab_err), 64'd0);

        // EN dropped after two reads; in-flight word still arrives.
        strm_if.READY = 1'b1;
        got_q.delete();
        clear_traces();
        for (int i = 0; i < 10; i++) push_word(WIDTH'(200 + i));
        apply_cycle();
        apply_cycle();
        EN = 1'b0;
        repeat (6) apply_cycle();
        check_output("en_reads", 64'(rd_cnt), 64'd2);
        check_output("en_inflight", 64'(got_q.size()), 64'd2);
        check_seq("en_first", 0, 2, WIDTH'(200));
        EN = 1'b1;
        run_until("en", 10, 40);
        check_seq("en_resume", 0, 10, WIDTH'(200));
        check_output("en_count", 64'(COUNT), 64'd110);

        // Reset while a word is buffered and another is in flight.
        strm_if.READY = 1'b0;
        got_q.delete();
        for (int i = 0; i < 6; i++) push_word(WIDTH'(300 + i));
        apply_cycle();
        apply_cycle();
        check_output("mid_valid", 64'(strm_if.VALID), 64'd1);
        check_output("mid_head", 64'(strm_if.dataOut), 64'd300);
        Rst = 1'b0;
        apply_cycle();
        Rst = 1'b1;
        check_output("mid_rst_valid", 64'(strm_if.VALID), 64'd0);
        check_output("mid_rst_data", 64'(strm_if.dataOut), 64'd0);
        check_output("mid_rst_count", 64'(COUNT), 64'd0);
        strm_if.READY = 1'b1;
        run_until("mid", 4, 30);
        repeat (3) apply_cycle();
        check_seq("mid_next", 0, 4, WIDTH'(302));
        check_output("mid_total", 64'(got_q.size()), 64'd4);
        check_output("mid_count", 64'(COUNT), 64'd4);
        check_output("final_rd_empty", 64'(rd_when_empty), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
